regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single write port of the 32x32 register bank between two writeback
//  requesters: A = main pipeline, B = long-latency unit (load/mul).
//  Round-robin valid/ready arbitration feeds a registered write stage that drives
//  RegWrite/writeReg/writeData directly.
//  Holds a pending-write scoreboard (x1..x31) so decode can stall on RAW hazards.
// PARAMETERS
//  DATA_W  32  write data width
//  ADDR_W  5   register index width (32 registers)
// PORTS
//  CLK        in   1       clock, rising edge
//  RST_n      in   1       asynchronous reset, active low
//  a_valid    in   1       requester A has a write
//  a_ready    out  1       A accepted this cycle
//  a_reg      in   ADDR_W  A destination register
//  a_data     in   DATA_W  A write data
//  b_valid    in   1       requester B has a write
//  b_ready    out  1       B accepted this cycle
//  b_reg      in   ADDR_W  B destination register
//  b_data     in   DATA_W  B write data
//  iss_valid  in   1       decode reserves a destination register
//  iss_reg    in   ADDR_W  register being reserved
//  chk_reg1   in   ADDR_W  source register 1 to check
//  chk_reg2   in   ADDR_W  source register 2 to check
//  chk_busy1  out  1       chk_reg1 has a pending write (combinational)
//  chk_busy2  out  1       chk_reg2 has a pending write (combinational)
//  pend_err   out  1       sticky: reservation made on an already-pending register
//  RegWrite   out  1       register bank write enable (registered)
//  writeReg   out  ADDR_W  register bank write index (registered)
//  writeData  out  DATA_W  register bank write data (registered)
// BEHAVIOUR
//  Reset (async, RST_n=0): RegWrite=0, writeReg=0, writeData=0, pend_err=0,
//   all pending bits 0, RR pointer = PRIO_A.
//  Handshake: X accepted when X_valid && X_ready. Ready is combinational from the
//   valids and the RR pointer. Requesters hold valid/reg/data stable until accepted.
//  Arbitration FSM (pointer), 2 states:
//   PRIO_A: A wins when both are valid.
//   PRIO_B: B wins when both are valid.
//  Pointer transitions: after a grant to A -> PRIO_B; after a grant to B -> PRIO_A;
//   no grant -> unchanged. Only one requester is valid -> it is granted.
//   At most one ready per cycle.
//  Write stage, 1-cycle latency: a grant in cycle t produces, in cycle t+1,
//   RegWrite=1 and the granted reg/data. The bank captures at the end of t+1;
//   the value is readable from t+2. No grant -> RegWrite=0; writeReg/writeData hold.
//   A write to x0 is accepted (ready=1), but RegWrite stays 0 for it.
//  Scoreboard, pending[31:1]:
//   Set at the edge when iss_valid && iss_reg!=0.
//   Cleared at the edge ending the write-stage cycle, i.e. when RegWrite=1 for that reg.
//   Set and clear on the same reg in the same cycle: set wins.
//   iss_valid on a reg already pending: the bit stays 1 and pend_err is set
//   (sticky until reset).
//   chk_busyN = pending[chk_regN]. A chk_reg of 0 always returns 0.
//  Reset mid-operation: the in-flight write stage is dropped (RegWrite=0 immediately,
//   asynchronously); pending bits are cleared; requesters must re-present.
// CONFIGURATION
//  REGWB_FWD_EN defined:
//   chk_busyN is forced to 0 when RegWrite && writeReg==chk_regN && chk_regN!=0.
//   Adds outputs fwd_hit1, fwd_hit2 (1 bit) and fwd_data1, fwd_data2 (DATA_W).
//   fwd_hitN=1 and fwd_dataN=writeData under that match; otherwise 0.
//   This saves one stall cycle per hazard.
//  REGWB_FWD_EN undefined:
//   No forwarding ports. chk_busyN stays 1 through the write-stage cycle.
// TESTING
//  1. Reset; a_valid=1, a_reg=5, a_data=0xDEADBEEF -> a_ready=1 in cycle 0;
//     cycle 1 RegWrite=1, writeReg=5, writeData=0xDEADBEEF; cycle 2 RegWrite=0.
//  2. A and B valid 4 cycles (A:reg3, B:reg7) from reset -> grants A,B,A,B;
//     a_ready/b_ready never both 1.
//  3. iss_valid reg 9; chk_reg1=9 -> chk_busy1=1 until B writes reg 9;
//     clears after the RegWrite cycle (FWD_EN: cleared during it, fwd_hit1=1).
//  4. a_reg=0, a_data=0x1234 -> a_ready=1, RegWrite stays 0;
//     iss_reg=0 -> chk_busy for reg 0 stays 0.
//  5. iss_valid reg 4 twice with no write between -> pend_err=1, stays 1;
//     same-cycle set+clear of reg 4 -> pending[4]=1.
//  6. Assert RST_n=0 while RegWrite=1 -> RegWrite=0 asynchronously;
//     all chk_busy=0, pend_err=0 after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register bank: round-robin between the main pipe (A)
// and the long-latency unit (B), registered write stage, RAW pending scoreboard.
// Optional forwarding of the in-flight write is enabled with `define REGWB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_reg,
    input  logic [ADDR_W-1:0] chk_reg1,
    input  logic [ADDR_W-1:0] chk_reg2,
    output logic              chk_busy1,
    output logic              chk_busy2,
`ifdef REGWB_FWD_EN
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
`endif
    output logic              pend_err,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData
);

    localparam int NREG = 1 << ADDR_W;

    typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} ptr_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rg;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    ptr_t            ptr_q, ptr_d;
    wb_req_t         gnt;
    logic            gnt_vld;
    logic            gnt_wr;
    logic [NREG-1:0] pending_q, pending_d;
    logic            err_d;

    // ---------------- round-robin pointer FSM ----------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) ptr_q <= PRIO_A;
        else        ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (a_ready)      ptr_d = PRIO_B;
        else if (b_ready) ptr_d = PRIO_A;
    end

    always_comb begin
        a_ready = a_valid && (!b_valid || ptr_q == PRIO_A);
        b_ready = b_valid && (!a_valid || ptr_q == PRIO_B);
    end

    // ---------------- write stage ----------------
    always_comb begin
        gnt_vld  = a_ready || b_ready;
        gnt.rg   = a_ready ? a_reg  : b_reg;
        gnt.data = a_ready ? a_data : b_data;
        // x0 writes are consumed but never reach the bank
        gnt_wr   = gnt_vld && (gnt.rg != '0);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            RegWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            RegWrite <= gnt_wr;
            if (gnt_wr) begin
                writeReg  <= gnt.rg;
                writeData <= gnt.data;
            end
        end
    end

    // ---------------- pending scoreboard ----------------
    always_comb begin
        pending_d = pending_q;
        if (RegWrite) pending_d[writeReg] = 1'b0;
        // applied after the clear so a same-cycle reservation wins
        if (iss_valid && iss_reg != '0) pending_d[iss_reg] = 1'b1;
        pending_d[0] = 1'b0;
        err_d = iss_valid && (iss_reg != '0) && pending_q[iss_reg];
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pending_q <= '0;
            pend_err  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            pend_err  <= pend_err | err_d;
        end
    end

`ifdef REGWB_FWD_EN
    logic hit1, hit2;

    always_comb begin
        hit1      = RegWrite && (writeReg == chk_reg1) && (chk_reg1 != '0);
        hit2      = RegWrite && (writeReg == chk_reg2) && (chk_reg2 != '0);
        chk_busy1 = pending_q[chk_reg1] && (chk_reg1 != '0) && !hit1;
        chk_busy2 = pending_q[chk_reg2] && (chk_reg2 != '0) && !hit2;
        fwd_hit1  = hit1;
        fwd_hit2  = hit2;
        fwd_data1 = hit1 ? writeData : '0;
        fwd_data2 = hit2 ? writeData : '0;
    end
`else
    always_comb begin
        chk_busy1 = pending_q[chk_reg1] && (chk_reg1 != '0);
        chk_busy2 = pending_q[chk_reg2] && (chk_reg2 != '0);
    end
`endif

endmodule
